tabellone: RTL and testbench
============================

TABELLONE -- requirements
Module: tabellone

Interface
REQ-001 SHALL have parameter CNT_W, default 4, width of per-match counters punti1/punti2/pareggi.
REQ-002 SHALL have parameter VIT_W, default 4, width of cumulative win counters vittorie1/vittorie2/vittoriepari.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port inizia  input  1  start-of-match strobe, same signal the game FSMD samples.
REQ-006 SHALL have port manche  input  2  per-round result from FSMD: 00 none, 01 player 1, 10 player 2, 11 tie.
REQ-007 SHALL have port partita  input  2  match result from FSMD: 00 running, 01 player 1, 10 player 2, 11 no winner.
REQ-008 SHALL have port punti1, punti2, pareggi  output  CNT_W each  current-match round wins and ties.
REQ-009 SHALL have port giocate  output  5  valid rounds counted in the current match.
REQ-010 SHALL have port vittorie1, vittorie2, vittoriepari  output  VIT_W each  cumulative match outcomes since reset.
REQ-011 SHALL have port rep_valid  output  1, rep_ready  input  1  report handshake.
REQ-012 SHALL have port rep_vincitore  output  2, rep_giocate  output  5  report payload: match result and rounds played.

Function
REQ-013 SHALL implement FSM states IDLE, GIOCO and REPORT; reset state is IDLE.
REQ-014 IDLE: manche and partita ignored; inizia=1 -> GIOCO, clear punti1/punti2/pareggi/giocate on the same edge.
REQ-015 GIOCO, per edge: manche=01 -> punti1+1; 10 -> punti2+1; 11 -> pareggi+1; any nonzero -> giocate+1; 00 -> no change.
REQ-016 GIOCO: partita!=00 -> REPORT; the manche of that same cycle is counted first and is included in rep_giocate.
REQ-017 On GIOCO->REPORT: latch rep_vincitore=partita and rep_giocate=giocate after the REQ-016 update; increment vittorie1 for partita 01, vittorie2 for 10, vittoriepari for 11.
REQ-018 rep_valid SHALL be 1 exactly while in REPORT, asserted the cycle after partita!=00 is sampled.
REQ-019 The payload SHALL be stable while rep_valid=1 and rep_ready=0.
REQ-020 A transfer occurs on an edge with rep_valid=1 and rep_ready=1; the next state is GIOCO (cleared) if inizia=1 or pend=1, else IDLE.
REQ-021 inizia=1 in REPORT without a transfer SHALL set internal flag pend; pend clears on the transfer.
REQ-022 inizia=1 in GIOCO SHALL abort the match: clear the per-match counters, stay in GIOCO, no report and no vittorie change; if partita!=00 on the same edge, inizia wins.
REQ-023 All counters SHALL saturate at all-ones (no wrap); a saturated giocate still latches 31 into rep_giocate.
REQ-024 All outputs SHALL be registered; counter updates are visible the cycle after the sampling edge.
REQ-025 manche and partita in REPORT SHALL be ignored.

Reset
REQ-026 rst_n=0 SHALL asynchronously force IDLE, clear pend and drive every output and counter to 0, including rep_valid=0 and rep_vincitore=00.
REQ-027 Reset mid-match or mid-report SHALL discard all state; the first edge after release behaves as IDLE.

Structure
REQ-028 Package tabellone_pkg SHALL hold the manche/partita code constants (NESSUNO=00, G1=01, G2=10, PARI=11) and the FSM state enum.
REQ-029 A single sub-module contatore_sat (parameterised width, enable, synchronous clear, saturating increment) SHALL be instantiated for each counter.

Verification
REQ-030 Reset, inizia=1, then manche 01,10,01,01 and partita=01 alongside the last manche -> rep_valid=1 next cycle, rep_vincitore=01, rep_giocate=4, punti1=3, punti2=1, vittorie1=1.
REQ-031 Hold rep_ready=0 for 5 cycles after rep_valid rises -> payload unchanged; rep_ready=1 -> rep_valid=0 next cycle, state IDLE.
REQ-032 inizia=1 in REPORT while rep_ready=0, then rep_ready=1 -> GIOCO, counters 0, vittorie preserved.
REQ-033 inizia=1 in GIOCO with punti2=2 -> punti2=0, no rep_valid, vittorie2 unchanged.
REQ-034 16 consecutive manche=11 -> pareggi=15 saturates, giocate=16; partita=11 -> vittoriepari+1, rep_giocate=16.
REQ-035 rst_n low mid-REPORT asynchronously, between edges -> rep_valid=0 and all counters 0 immediately; manche=01 after release is ignored until inizia.

Source files
------------

// File: rtl/tabellone_pkg.sv
// Shared codes and FSM state type for the scoreboard (tabellone) block.
package tabellone_pkg;

  localparam logic [1:0] NESSUNO = 2'b00;
  localparam logic [1:0] G1      = 2'b01;
  localparam logic [1:0] G2      = 2'b10;
  localparam logic [1:0] PARI    = 2'b11;

  localparam int GIOC_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GIOCO  = 2'd1,
    REPORT = 2'd2
  } stato_t;

endpackage

// File: rtl/contatore_sat.sv
// Saturating up-counter with enable and synchronous clear; clear has priority.
module contatore_sat #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_en && (r_q != {W{1'b1}})) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/tabellone.sv
// Scoreboard: counts round results of the running match, tallies match outcomes
// and offers a one-entry report with valid/ready handshake at the end of each match.
module tabellone
  import tabellone_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int VIT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inizia,
  input  logic [1:0]       manche,
  input  logic [1:0]       partita,
  output logic [CNT_W-1:0] punti1,
  output logic [CNT_W-1:0] punti2,
  output logic [CNT_W-1:0] pareggi,
  output logic [4:0]       giocate,
  output logic [VIT_W-1:0] vittorie1,
  output logic [VIT_W-1:0] vittorie2,
  output logic [VIT_W-1:0] vittoriepari,
  output logic             rep_valid,
  input  logic             rep_ready,
  output logic [1:0]       rep_vincitore,
  output logic [4:0]       rep_giocate
);

  stato_t              r_stato;
  stato_t              w_stato_next;
  logic                r_pend;
  logic                r_rep_valid;
  logic [1:0]          r_rep_vincitore;
  logic [GIOC_W-1:0]   r_rep_giocate;

  logic                w_gioco_attivo;
  logic                w_transfer;
  logic                w_clr_match;
  logic                w_fine;
  logic [GIOC_W-1:0]   w_giocate;
  logic [GIOC_W-1:0]   w_giocate_dopo;
  logic [CNT_W-1:0]    w_punti [3];
  logic [VIT_W-1:0]    w_vitt  [3];

  // inizia in GIOCO aborts the match, so it masks both counting and match end
  assign w_gioco_attivo = (r_stato == GIOCO) && !inizia;
  assign w_transfer     = (r_stato == REPORT) && rep_ready;
  assign w_fine         = w_gioco_attivo && (partita != NESSUNO);
  assign w_clr_match    = (((r_stato == IDLE) || (r_stato == GIOCO)) && inizia)
                        || (w_transfer && (inizia || r_pend));

  // Round total including this cycle's round, for the report latched on match end
  assign w_giocate_dopo = ((manche != NESSUNO) && (w_giocate != {GIOC_W{1'b1}}))
                        ? w_giocate + 1'b1 : w_giocate;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      localparam logic [1:0] CODICE = 2'(gi + 1);

      contatore_sat #(.W(CNT_W)) u_punti (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_gioco_attivo && (manche == CODICE)),
        .i_clr (w_clr_match),
        .o_q   (w_punti[gi])
      );

      contatore_sat #(.W(VIT_W)) u_vitt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_fine && (partita == CODICE)),
        .i_clr (1'b0),
        .o_q   (w_vitt[gi])
      );
    end
  endgenerate

  contatore_sat #(.W(GIOC_W)) u_giocate (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_gioco_attivo && (manche != NESSUNO)),
    .i_clr (w_clr_match),
    .o_q   (w_giocate)
  );

  always_comb begin
    w_stato_next = r_stato;
    case (r_stato)
      IDLE:    if (inizia) w_stato_next = GIOCO;
      GIOCO:   if (w_fine) w_stato_next = REPORT;
      REPORT:  if (w_transfer) w_stato_next = (inizia || r_pend) ? GIOCO : IDLE;
      default: w_stato_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stato <= IDLE;
    end else begin
      r_stato <= w_stato_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend          <= 1'b0;
      r_rep_valid     <= 1'b0;
      r_rep_vincitore <= 2'b00;
      r_rep_giocate   <= '0;
    end else begin
      r_rep_valid <= (w_stato_next == REPORT);
      if (w_transfer) begin
        r_pend <= 1'b0;
      end else if ((r_stato == REPORT) && inizia) begin
        r_pend <= 1'b1;
      end
      if (w_fine) begin
        r_rep_vincitore <= partita;
        r_rep_giocate   <= w_giocate_dopo;
      end
    end
  end

  assign punti1        = w_punti[0];
  assign punti2        = w_punti[1];
  assign pareggi       = w_punti[2];
  assign giocate       = w_giocate;
  assign vittorie1     = w_vitt[0];
  assign vittorie2     = w_vitt[1];
  assign vittoriepari  = w_vitt[2];
  assign rep_valid     = r_rep_valid;
  assign rep_vincitore = r_rep_vincitore;
  assign rep_giocate   = r_rep_giocate;

endmodule

// File: tb/tb_tabellone.sv
// Directed bench for tabellone: match counting, report handshake, abort, saturation, async reset.
module tb_tabellone;

  logic       clk;
  logic       rst_n;
  logic       inizia;
  logic [1:0] manche;
  logic [1:0] partita;
  logic [3:0] punti1, punti2, pareggi;
  logic [4:0] giocate;
  logic [3:0] vittorie1, vittorie2, vittoriepari;
  logic       rep_valid;
  logic       rep_ready;
  logic [1:0] rep_vincitore;
  logic [4:0] rep_giocate;

  int checks   = 0;
  int failures = 0;

  tabellone #(.CNT_W(4), .VIT_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inizia        (inizia),
    .manche        (manche),
    .partita       (partita),
    .punti1        (punti1),
    .punti2        (punti2),
    .pareggi       (pareggi),
    .giocate       (giocate),
    .vittorie1     (vittorie1),
    .vittorie2     (vittorie2),
    .vittoriepari  (vittoriepari),
    .rep_valid     (rep_valid),
    .rep_ready     (rep_ready),
    .rep_vincitore (rep_vincitore),
    .rep_giocate   (rep_giocate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  // Advance one edge; inputs are changed and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; inizia = 1'b0; manche = 2'b00; partita = 2'b00; rep_ready = 1'b0;
    #12;
    checks++;
    if ({punti1, punti2, pareggi, giocate, vittorie1, vittorie2, vittoriepari,
         rep_valid, rep_vincitore, rep_giocate} !== 40'd0) begin
      failures++;
      $display("FAIL reset_outputs got_valid=%0b got_p1=%0d got_gioc=%0d exp=all_zero",
               rep_valid, punti1, giocate);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (rep_valid !== 1'b0 || giocate !== 5'd0) begin
      failures++;
      $display("FAIL reset_release got_valid=%0b got_gioc=%0d exp_valid=0 exp_gioc=0", rep_valid, giocate);
    end
    $display("test_reset done");
  endtask

  task automatic test_match();
    logic [1:0] seq [4];
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b01;
    inizia = 1'b1; tick(); inizia = 1'b0;
    for (int i = 0; i < 4; i++) begin
      manche  = seq[i];
      partita = (i == 3) ? 2'b01 : 2'b00;
      tick();
      if (i == 2) begin
        checks++;
        if (rep_valid !== 1'b0 || giocate !== 5'd3) begin
          failures++;
          $display("FAIL match_mid got_valid=%0b got_gioc=%0d exp_valid=0 exp_gioc=3", rep_valid, giocate);
        end
      end
    end
    manche = 2'b00; partita = 2'b00;
    checks++;
    if (rep_valid !== 1'b1 || rep_vincitore !== 2'b01 || rep_giocate !== 5'd4) begin
      failures++;
      $display("FAIL match_report got_valid=%0b got_vinc=%0d got_gioc=%0d exp=1/1/4",
               rep_valid, rep_vincitore, rep_giocate);
    end
    checks++;
    if (punti1 !== 4'd3 || punti2 !== 4'd1 || vittorie1 !== 4'd1 || vittorie2 !== 4'd0) begin
      failures++;
      $display("FAIL match_counters got_p1=%0d got_p2=%0d got_v1=%0d got_v2=%0d exp=3/1/1/0",
               punti1, punti2, vittorie1, vittorie2);
    end
    $display("test_match done");
  endtask

  task automatic test_hold();
    rep_ready = 1'b0;
    manche = 2'b10; partita = 2'b10;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (rep_valid !== 1'b1 || rep_vincitore !== 2'b01 || rep_giocate !== 5'd4 || punti2 !== 4'd1) begin
        failures++;
        $display("FAIL hold_cycle%0d got_valid=%0b got_vinc=%0d got_gioc=%0d exp=1/1/4",
                 i, rep_valid, rep_vincitore, rep_giocate);
      end
    end
    manche = 2'b00; partita = 2'b00;
    rep_ready = 1'b1; tick(); rep_ready = 1'b0;
    checks++;
    if (rep_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_transfer got_valid=%0b exp_valid=0", rep_valid);
    end
    manche = 2'b01; partita = 2'b01; tick(); tick();
    manche = 2'b00; partita = 2'b00;
    checks++;
    if (punti1 !== 4'd3 || giocate !== 5'd4 || rep_valid !== 1'b0 || vittorie1 !== 4'd1) begin
      failures++;
      $display("FAIL idle_ignore got_p1=%0d got_gioc=%0d got_valid=%0b got_v1=%0d exp=3/4/0/1",
               punti1, giocate, rep_valid, vittorie1);
    end
    $display("test_hold done");
  endtask

  task automatic test_pend();
    inizia = 1'b1; tick(); inizia = 1'b0;
    checks++;
    if (punti1 !== 4'd0 || giocate !== 5'd0) begin
      failures++;
      $display("FAIL pend_start got_p1=%0d got_gioc=%0d exp=0/0", punti1, giocate);
    end
    manche = 2'b10; partita = 2'b10; tick();
    manche = 2'b00; partita = 2'b00;
    checks++;
    if (rep_valid !== 1'b1 || rep_vincitore !== 2'b10 || rep_giocate !== 5'd1 || vittorie2 !== 4'd1) begin
      failures++;
      $display("FAIL pend_report got_valid=%0b got_vinc=%0d got_gioc=%0d got_v2=%0d exp=1/2/1/1",
               rep_valid, rep_vincitore, rep_giocate, vittorie2);
    end
    inizia = 1'b1; tick(); inizia = 1'b0; tick();
    checks++;
    if (rep_valid !== 1'b1 || punti2 !== 4'd1) begin
      failures++;
      $display("FAIL pend_wait got_valid=%0b got_p2=%0d exp=1/1", rep_valid, punti2);
    end
    rep_ready = 1'b1; tick(); rep_ready = 1'b0;
    checks++;
    if (rep_valid !== 1'b0 || punti2 !== 4'd0 || giocate !== 5'd0 ||
        vittorie1 !== 4'd1 || vittorie2 !== 4'd1) begin
      failures++;
      $display("FAIL pend_restart got_valid=%0b got_p2=%0d got_gioc=%0d got_v1=%0d got_v2=%0d exp=0/0/0/1/1",
               rep_valid, punti2, giocate, vittorie1, vittorie2);
    end
    manche = 2'b01; tick(); manche = 2'b00;
    checks++;
    if (punti1 !== 4'd1 || giocate !== 5'd1) begin
      failures++;
      $display("FAIL pend_in_gioco got_p1=%0d got_gioc=%0d exp=1/1", punti1, giocate);
    end
    $display("test_pend done");
  endtask

  task automatic test_abort();
    manche = 2'b10; tick(); tick();
    checks++;
    if (punti2 !== 4'd2) begin
      failures++;
      $display("FAIL abort_pre got_p2=%0d exp=2", punti2);
    end
    inizia = 1'b1; manche = 2'b10; partita = 2'b10; tick();
    inizia = 1'b0; manche = 2'b00; partita = 2'b00;
    checks++;
    if (punti2 !== 4'd0 || punti1 !== 4'd0 || giocate !== 5'd0 || rep_valid !== 1'b0 || vittorie2 !== 4'd1) begin
      failures++;
      $display("FAIL abort got_p2=%0d got_p1=%0d got_gioc=%0d got_valid=%0b got_v2=%0d exp=0/0/0/0/1",
               punti2, punti1, giocate, rep_valid, vittorie2);
    end
    tick();
    checks++;
    if (rep_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_report got_valid=%0b exp=0", rep_valid);
    end
    $display("test_abort done");
  endtask

  task automatic test_tie_saturation();
    manche = 2'b11;
    for (int i = 0; i < 16; i++) tick();
    manche = 2'b00;
    checks++;
    if (pareggi !== 4'd15 || giocate !== 5'd16) begin
      failures++;
      $display("FAIL tie_sat got_par=%0d got_gioc=%0d exp=15/16", pareggi, giocate);
    end
    partita = 2'b11; tick(); partita = 2'b00;
    checks++;
    if (rep_valid !== 1'b1 || rep_vincitore !== 2'b11 || rep_giocate !== 5'd16 || vittoriepari !== 4'd1) begin
      failures++;
      $display("FAIL tie_report got_valid=%0b got_vinc=%0d got_gioc=%0d got_vp=%0d exp=1/3/16/1",
               rep_valid, rep_vincitore, rep_giocate, vittoriepari);
    end
    inizia = 1'b1; rep_ready = 1'b1; tick(); inizia = 1'b0; rep_ready = 1'b0;
    $display("test_tie_saturation done");
  endtask

  task automatic test_giocate_saturation();
    manche = 2'b01;
    for (int i = 0; i < 33; i++) begin
      partita = (i == 32) ? 2'b01 : 2'b00;
      tick();
    end
    manche = 2'b00; partita = 2'b00;
    checks++;
    if (rep_valid !== 1'b1 || rep_giocate !== 5'd31 || giocate !== 5'd31 ||
        punti1 !== 4'd15 || vittorie1 !== 4'd2) begin
      failures++;
      $display("FAIL gioc_sat got_valid=%0b got_rgioc=%0d got_gioc=%0d got_p1=%0d got_v1=%0d exp=1/31/31/15/2",
               rep_valid, rep_giocate, giocate, punti1, vittorie1);
    end
    $display("test_giocate_saturation done");
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({punti1, punti2, pareggi, giocate, vittorie1, vittorie2, vittoriepari,
         rep_valid, rep_vincitore, rep_giocate} !== 40'd0) begin
      failures++;
      $display("FAIL async_reset got_valid=%0b got_p1=%0d got_gioc=%0d got_v1=%0d exp=all_zero",
               rep_valid, punti1, giocate, vittorie1);
    end
    #2;
    rst_n = 1'b1;
    manche = 2'b01; partita = 2'b01; rep_ready = 1'b1;
    tick(); tick();
    manche = 2'b00; partita = 2'b00; rep_ready = 1'b0;
    checks++;
    if (punti1 !== 4'd0 || giocate !== 5'd0 || rep_valid !== 1'b0 || vittorie1 !== 4'd0) begin
      failures++;
      $display("FAIL post_reset_idle got_p1=%0d got_gioc=%0d got_valid=%0b got_v1=%0d exp=0/0/0/0",
               punti1, giocate, rep_valid, vittorie1);
    end
    inizia = 1'b1; tick(); inizia = 1'b0;
    manche = 2'b01; tick(); manche = 2'b00;
    checks++;
    if (punti1 !== 4'd1) begin
      failures++;
      $display("FAIL post_reset_start got_p1=%0d exp=1", punti1);
    end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_match();
    test_hold();
    test_pend();
    test_abort();
    test_tie_saturation();
    test_giocate_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
